// File: rtl/apb_sram_ws_if.sv
// APB3 bus bundle between the CPU peripheral-bus master and the apb_sram_ws slave.
// Latency: none, wires only.
// Backpressure: the slave stretches the access phase by holding pready low.
// Signals: paddr/pwrite/psel/penable/pwdata/pstrb driven by the master;
//          prdata/pready/pslverr driven by the slave.
interface apb_sram_ws_if;
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_sram_ws.sv
// APB3 slave SRAM: 2**(ADDR_W-2) x 32-bit words, byte strobes, error on bad address.
// Latency: pready in cycle S+1+WAIT_STATES after the setup cycle S.
// Backpressure: access phase held by pready=0 while the wait counter drains.
// Ports: clk, rst (sync, active-high); bus = slave side of apb_sram_ws_if
//        (paddr, pwrite, psel, penable, pwdata, pstrb in; prdata, pready, pslverr out).
module apb_sram_ws #(
  parameter int ADDR_W          = 12,
  parameter int WAIT_STATES     = 1,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  apb_sram_ws_if.slave bus
);

  localparam int         DEPTH = 1 << (ADDR_W - 2);
  localparam logic [2:0] WS    = 3'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        err_q;
  logic [31:0] rd_q;
  logic [31:0] mem [DEPTH];

  logic [ADDR_W-3:0] idx;
  logic              err_now;
  logic              setup;
  logic              pready;

  assign idx   = bus.paddr[ADDR_W-1:2];
  assign setup = bus.psel && !bus.penable;

  // Any address bit above the decoded window, or a sub-word offset when
  // misalignment is treated as an error, marks the whole transfer as failed.
  assign err_now = ((bus.paddr >> ADDR_W) != 32'h0) ||
                   (ERR_ON_MISALIGN && (bus.paddr[1:0] != 2'b00));

  // Gating with rst keeps the bus quiet throughout reset, including the
  // first reset cycle when state may still hold ACCESS.
  assign pready = !rst && (state == ACCESS) && bus.psel && bus.penable &&
                  (cnt == 3'd0);

  assign bus.pready  = pready;
  assign bus.pslverr = pready && err_q;
  assign bus.prdata  = (pready && !bus.pwrite && !err_q) ? rd_q : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      err_q <= 1'b0;
      rd_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          // psel&penable without a preceding setup phase is ignored here.
          if (setup) begin
            cnt   <= WS;
            err_q <= err_now;
            rd_q  <= mem[idx];
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.psel) begin
            // Master abort: drop the transfer without completing it.
            state <= IDLE;
          end else if (bus.penable) begin
            if (cnt == 3'd0) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset so it can map onto block RAM. The write lands on
  // the edge that ends the pready cycle; a read set up on the next cycle
  // samples the array one edge later, so no bypass path is required.
  always_ff @(posedge clk) begin
    if (pready && bus.pwrite && !err_q) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.pstrb[n]) begin
          mem[idx][8*n +: 8] <= bus.pwdata[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_sram_ws.sv
module tb_apb_sram_ws;

  // Five instances cover the parameter points the checks need:
  //   d0: WS=1 misalign-err  d1: WS=0  d2: WS=3  d3: WS=7  d4: WS=1 misalign-ignored
  localparam logic [4:0][2:0] WS_TAB  = {3'd1, 3'd7, 3'd3, 3'd0, 3'd1};
  localparam logic [4:0]      MIS_TAB = 5'b01111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic        pwrite, psel, penable;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  dsel;

  logic [4:0]  rdy_v, err_v;
  logic [31:0] rd_v [5];
  logic        o_rdy, o_err;
  logic [31:0] o_rd;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [4][64];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    apb_sram_ws_if bus ();
    assign bus.paddr   = paddr;
    assign bus.pwrite  = pwrite;
    assign bus.psel    = psel && (dsel == 3'(k));
    assign bus.penable = penable;
    assign bus.pwdata  = pwdata;
    assign bus.pstrb   = pstrb;
    assign rdy_v[k]    = bus.pready;
    assign err_v[k]    = bus.pslverr;
    assign rd_v[k]     = bus.prdata;
    apb_sram_ws #(
      .ADDR_W(12),
      .WAIT_STATES(int'(WS_TAB[k])),
      .ERR_ON_MISALIGN(MIS_TAB[k])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  always_comb begin
    o_rdy = 1'b0;
    o_err = 1'b0;
    o_rd  = 32'h0;
    if (dsel < 3'd5) begin
      o_rdy = rdy_v[dsel];
      o_err = err_v[dsel];
      o_rd  = rd_v[dsel];
    end
  end

  // Byte-lane merge from the strobe rule: lanes with strobe set take new data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] mask;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    r = $urandom_range(0, 15);
    if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
    else if (r == 1) a = a | (32'h1 << $urandom_range(12, 31));
    return a;
  endfunction

  // Drives one complete transfer starting just after a posedge; returns just
  // after the edge that ends the pready cycle. lat counts cycles from setup.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int lat, output logic early);
    bit done;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    early = o_rdy;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1; done = 0; rd = 32'h0; err = 1'b0;
    while (!done && lat <= 20) begin
      @(negedge clk);
      if (o_rdy === 1'b1) begin
        done = 1; rd = o_rd; err = o_err;
      end
      @(posedge clk); #1;
      if (!done) lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err, early; int lat;
    dsel = 3'd0; rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (o_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_pready cyc%0d got %b want 0", i, o_rdy); end
      vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL reset_pslverr cyc%0d got %b want 0", i, o_err); end
      vectors++; if (o_rd !== 32'h0) begin miscompares++; $display("FAIL reset_prdata cyc%0d got %h want 0", i, o_rd); end
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(1'b1, 32'h0, 32'h12345678, 4'hF, rd, err, lat, early);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL post_reset_lat got %0d want 2", lat); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL post_reset_err got %b want 0", err); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err, early; int lat;
    dsel = 3'd0;
    xfer(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, rd, err, lat, early);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr_lat got %0d want 2", lat); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wr_err got %b want 0", err); end
    xfer(1'b0, 32'h010, 32'h0, 4'h0, rd, err, lat, early);
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL rd_pulse got %b want 0", early); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd_lat got %0d want 2", lat); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rd_err got %b want 0", err); end
    idle(2);
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err, early; int lat;
    dsel = 3'd0;
    xfer(1'b1, 32'h020, 32'h11223344, 4'hF, rd, err, lat, early);
    xfer(1'b1, 32'h020, 32'hAABBCCDD, 4'b0101, rd, err, lat, early);
    xfer(1'b0, 32'h020, 32'h0, 4'h0, rd, err, lat, early);
    vectors++; if (rd !== 32'h11BB33DD) begin miscompares++; $display("FAIL strb_0101 got %h want 11bb33dd", rd); end
    xfer(1'b1, 32'h020, 32'hFFFFFFFF, 4'h0, rd, err, lat, early);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL strb_zero_err got %b want 0", err); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL strb_zero_lat got %0d want 2", lat); end
    xfer(1'b0, 32'h020, 32'h0, 4'h0, rd, err, lat, early);
    vectors++; if (rd !== 32'h11BB33DD) begin miscompares++; $display("FAIL strb_zero_data got %h want 11bb33dd", rd); end
    idle(1);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err, early; int lat;
    dsel = 3'd0;
    xfer(1'b1, 32'h000, 32'h5A5A5A5A, 4'hF, rd, err, lat, early);
    xfer(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, err, lat, early);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL oor_wr_err got %b want 1", err); end
    xfer(1'b0, 32'h000, 32'h0, 4'h0, rd, err, lat, early);
    vectors++; if (rd !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL oor_wr_alias got %h want 5a5a5a5a", rd); end
    xfer(1'b0, 32'h013, 32'h0, 4'h0, rd, err, lat, early);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL misalign_err got %b want 1", err); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL misalign_data got %h want 0", rd); end
    idle(1);
    dsel = 3'd4;
    xfer(1'b1, 32'h010, 32'hCAFEF00D, 4'hF, rd, err, lat, early);
    xfer(1'b0, 32'h013, 32'h0, 4'h0, rd, err, lat, early);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL nomis_err got %b want 0", err); end
    vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL nomis_data got %h want cafef00d", rd); end
    idle(1);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err, early; int lat;
    dsel = 3'd2;
    xfer(1'b1, 32'h040, 32'h0BADF00D, 4'hF, rd, err, lat, early);
    idle(1);
    // Master abort at S+2.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h040; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    vectors++; if (o_rdy !== 1'b0) begin miscompares++; $display("FAIL abort_s1 got %b want 0", o_rdy); end
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (o_rdy !== 1'b0 || o_err !== 1'b0) begin miscompares++; $display("FAIL abort_quiet cyc%0d got %b%b want 00", i, o_rdy, o_err); end
    end
    @(posedge clk); #1;
    xfer(1'b0, 32'h040, 32'h0, 4'h0, rd, err, lat, early);
    vectors++; if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL abort_data got %h want 0badf00d", rd); end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL abort_next_lat got %0d want 4", lat); end
    idle(1);
    // Reset at S+2 with the access phase still asserted.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h040; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (o_rdy !== 1'b0) begin miscompares++; $display("FAIL rstmid_pready cyc%0d got %b want 0", i, o_rdy); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    // psel&penable without setup must be ignored if the FSM is really in IDLE.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (o_rdy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle cyc%0d got %b want 0", i, o_rdy); end
      @(posedge clk); #1;
    end
    idle(1);
    xfer(1'b0, 32'h040, 32'h0, 4'h0, rd, err, lat, early);
    vectors++; if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL rstmid_data got %h want 0badf00d", rd); end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rstmid_lat got %0d want 4", lat); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, a, wd, exp_rd; logic err, early, exp_err, w; logic [3:0] st; int lat, ws;
    for (int d = 1; d <= 3; d++) begin
      dsel = 3'(d);
      ws = int'(WS_TAB[d]);
      for (int i = 0; i < 64; i++) begin
        wd = $urandom;
        ref_mem[d][i] = wd;
        xfer(1'b1, 32'(i * 4), wd, 4'hF, rd, err, lat, early);
      end
      for (int i = 0; i < 350; i++) begin
        w = (i % 2 == 0);
        if (!w && ($urandom_range(0, 1) == 0)) a = paddr;
        else a = rand_addr();
        wd = $urandom;
        st = 4'($urandom);
        exp_err = ((a >> 12) != 0) || (a[1:0] != 2'b00);
        exp_rd = (w || exp_err) ? 32'h0 : ref_mem[d][a[7:2]];
        xfer(w, a, wd, st, rd, err, lat, early);
        if (w && !exp_err) ref_mem[d][a[7:2]] = merge(ref_mem[d][a[7:2]], wd, st);
        vectors++; if (lat !== ws + 1) begin miscompares++; $display("FAIL sweep_lat d%0d #%0d got %0d want %0d", d, i, lat, ws + 1); end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL sweep_pulse d%0d #%0d got %b want 0", d, i, early); end
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL sweep_err d%0d #%0d a=%h got %b want %b", d, i, a, err, exp_err); end
        vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL sweep_data d%0d #%0d a=%h got %h want %h", d, i, a, rd, exp_rd); end
      end
      idle(2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_errors();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_sram_ws.md
# apb_sram_ws

APB3 slave SRAM peripheral with parametrised depth, byte-lane write strobes, a programmable number of wait states, and error reporting. It succeeds the zero-wait, word-only APB RAM on the CPU's peripheral bus. It uses a registered synchronous read, so it maps onto FPGA block RAM. It reports out-of-range and misaligned accesses through PSLVERR instead of aliasing or corrupting them.

## Interface
- ADDR_W, 12: byte-address bits decoded. Depth is 2**(ADDR_W-2) 32-bit words. Legal range is 4..16.
- WAIT_STATES, 1: extra access-phase cycles before PREADY. Legal range is 0..7.
- ERR_ON_MISALIGN, 1: when 1, PADDR[1:0] != 0 is an error. When 0, PADDR[1:0] is ignored.
- PCLK  input  1  APB clock. The only clock.
- PRESET  input  1  reset, synchronous, active-high.
- PADDR  input  32  byte address, relative to this slave's base.
- PWRITE  input  1  1 = write, 0 = read.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PWDATA  input  32  write data.
- PSTRB  input  4  byte-lane write enables. Bit n enables PWDATA[8n+7:8n]. Ignored on reads.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer completes this cycle.
- PSLVERR  output  1  transfer error. Valid only while PREADY=1.

## Operation
- Storage is a 32-bit word array indexed by PADDR[ADDR_W-1:2]. Contents are not reset.
- FSM has two states: IDLE and ACCESS. A 3-bit wait counter `cnt` runs alongside it.
- In IDLE:
  - A setup phase (PSEL=1, PENABLE=0) loads cnt=WAIT_STATES and moves the FSM to ACCESS.
  - On the same edge, rd_q captures mem[PADDR[ADDR_W-1:2]] (registered read).
  - On the same edge, err_q latches the error for this transfer.
- err_q = (PADDR[31:ADDR_W] != 0) OR (ERR_ON_MISALIGN AND PADDR[1:0] != 0).
- In ACCESS:
  - PREADY = PSEL & PENABLE & (cnt == 0).
  - While cnt != 0 and PSEL & PENABLE: cnt decrements by 1 per cycle.
  - On PREADY=1: the FSM returns to IDLE. The next cycle may be a new setup phase (back-to-back transfers).
- Write commit happens at the PCLK edge ending the PREADY cycle, only when PWRITE=1 and err_q=0.
  - Each byte lane with PSTRB[n]=1 is updated; lanes with PSTRB[n]=0 keep their old value.
  - PSTRB=4'b0000 completes normally with no change and PSLVERR=0.
- PRDATA = rd_q only when PREADY=1, PWRITE=0 and err_q=0. Otherwise PRDATA is 32'h0.
- PSLVERR = PREADY & err_q.
  - An errored write changes no memory.
  - An errored read returns PRDATA=0.
- Master abort: PSEL falls while in ACCESS before PREADY. The FSM returns to IDLE, no write occurs, and PREADY/PSLVERR stay 0.
- Protocol violation: PSEL & PENABLE seen while in IDLE. It is ignored with PREADY=0, and the FSM waits for a proper setup phase.
- Reset:
  - PRESET=1 at any edge forces IDLE, cnt=0, err_q=0 and rd_q=0.
  - A pending write is dropped.
  - Outputs are PREADY=0, PSLVERR=0, PRDATA=0 from the cycle after the reset edge, and throughout reset.

## Timing
- Latency is measured from the setup cycle S, the first cycle of the transfer.
- PREADY is high in cycle S+1+WAIT_STATES.
  - WAIT_STATES=0 gives a 2-cycle APB transfer.
  - The default WAIT_STATES=1 gives 3 cycles.
- PREADY is high for exactly one cycle per transfer.
- PRDATA and PSLVERR are combinational from registered state and valid in the PREADY cycle.
- Write to word A completing at edge E, followed by a read of A with its setup in the cycle after E: the read returns the new data. No forwarding is needed because the read is captured one edge later.
- Throughput is one transfer per 2+WAIT_STATES cycles.

## Test plan
- Reset: hold PRESET for 3 cycles with PSEL=1, PENABLE=1 -> PREADY=0, PSLVERR=0, PRDATA=0 every cycle. The first transfer after release completes normally.
- Write/read, WAIT_STATES=1: write 32'hDEADBEEF to 0x010 with PSTRB=4'hF, then read 0x010 -> each PREADY occurs at S+2, read PRDATA=32'hDEADBEEF, PSLVERR=0.
- Byte strobes: word 0x020 holds 32'h11223344; write 32'hAABBCCDD with PSTRB=4'b0101 -> readback 32'h11BB33DD. A write with PSTRB=0 leaves the word unchanged.
- Errors, ADDR_W=12:
  - Write to 0x1000 -> PSLVERR=1 in the PREADY cycle, and word 0x000 is unchanged.
  - Read of 0x013 with ERR_ON_MISALIGN=1 -> PSLVERR=1, PRDATA=0.
  - Read of 0x013 with ERR_ON_MISALIGN=0 -> returns word 0x010.
- Wait sweep over WAIT_STATES=0,3,7: back-to-back write/read pairs -> PREADY at S+1, S+4 and S+8 respectively, one-cycle pulse, data matches a reference model over 1000 random transfers.
- Abort/reset mid-transfer:
  - WAIT_STATES=3, write setup to 0x040, PSEL dropped at S+2 -> no PREADY and word unchanged.
  - Repeat with PRESET asserted at S+2 -> same result, and FSM back in IDLE.
